// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with fixed-select or round-robin grant and one output register.
// Define STREAM_MUX_LOCK_EN to add in_last and a packet lock that holds the grant until the last beat.
module stream_mux_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
`ifdef STREAM_MUX_LOCK_EN
  input  logic [CHANNELS-1:0]       in_last,
`endif
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic             load;
  logic             grant;
  logic             xfer;
  logic [SEL_W-1:0] g;
  logic [SEL_W-1:0] ptr;
  logic             rr_hit;
  logic [SEL_W-1:0] rr_g;
  logic [SEL_W-1:0] rr_c;
  int unsigned      rr_idx;
  logic             fx_hit;

  assign load = !out_valid || out_ready;

  // Scan ptr+1, ptr+2, ... modulo CHANNELS; first valid channel wins.
  always_comb begin
    rr_hit = 1'b0;
    rr_g   = ptr;
    rr_idx = 0;
    rr_c   = '0;
    for (int unsigned i = 1; i <= CHANNELS; i++) begin
      rr_idx = (32'(ptr) + i) % CHANNELS;
      rr_c   = SEL_W'(rr_idx);
      if (!rr_hit && in_valid[rr_c]) begin
        rr_hit = 1'b1;
        rr_g   = rr_c;
      end
    end
  end

  always_comb begin
    fx_hit = 1'b0;
    if (32'(sel) < CHANNELS) fx_hit = in_valid[sel];
  end

`ifdef STREAM_MUX_LOCK_EN
  typedef enum logic {IDLE, LOCKED} lock_state_t;
  lock_state_t      state, state_nx;
  logic [SEL_W-1:0] lock_ch;
  logic             locked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lock_ch <= '0;
    end else begin
      state <= state_nx;
      if (xfer && state == IDLE) lock_ch <= g;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (xfer && !in_last[g]) state_nx = LOCKED;
      LOCKED:  if (xfer && in_last[g])  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  always_comb begin
    if (locked) begin
      g     = lock_ch;
      grant = in_valid[lock_ch];
    end else if (mode) begin
      g     = rr_g;
      grant = rr_hit;
    end else begin
      g     = sel;
      grant = fx_hit;
    end
  end
`else
  always_comb begin
    if (mode) begin
      g     = rr_g;
      grant = rr_hit;
    end else begin
      g     = sel;
      grant = fx_hit;
    end
  end
`endif

  // rst_n gates the handshake so no channel sees ready while reset is held.
  assign xfer = load && grant && rst_n;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[g] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SEL_W'(CHANNELS - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[32'(g)*WIDTH +: WIDTH];
      out_chan  <= g;
      ptr       <= g;
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: a queue-based reference model predicts grants and beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_stream_mux_rr;
  localparam int W  = 8;
  localparam int C  = 8;
  localparam int SW = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [C*W-1:0] in_data;
  logic [C-1:0]   in_valid;
  logic [C-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_chan;
  logic           out_valid;
  logic           out_ready;
`ifdef STREAM_MUX_LOCK_EN
  logic [C-1:0]   in_last;
  logic [4:0]     in_last5;
`endif

  logic [5*W-1:0] in_data5;
  logic [4:0]     in_valid5;
  logic [4:0]     in_ready5;
  logic           mode5;
  logic [2:0]     sel5;
  logic [W-1:0]   out_data5;
  logic [2:0]     out_chan5;
  logic           out_valid5;
  logic           out_ready5;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
`ifdef STREAM_MUX_LOCK_EN
    .in_last(in_last),
`endif
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(W), .CHANNELS(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data5), .in_valid(in_valid5),
`ifdef STREAM_MUX_LOCK_EN
    .in_last(in_last5),
`endif
    .in_ready(in_ready5), .mode(mode5), .sel(sel5), .out_data(out_data5),
    .out_chan(out_chan5), .out_valid(out_valid5), .out_ready(out_ready5)
  );

  typedef struct {
    int         ch;
    logic [7:0] data;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    m_ptr;
  bit    m_valid;
  bit    m_locked;
  int    m_lock_ch;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a beat is consumed when out_valid && out_ready; it must match the oldest prediction.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 32'(out_chan), 32'hFFFF_FFFF);
      end else begin
        beat_t b;
        b = sb.pop_front();
        chk("out_chan", 32'(out_chan), 32'(b.ch));
        chk("out_data", 32'(out_data), 32'(b.data));
      end
    end
  end

  // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
  task automatic step();
    int       gch;
    bit       ld;
    logic [C-1:0] exp_rdy;
    gch = -1;
    ld  = !m_valid || out_ready;
    if (m_locked) begin
      if (in_valid[m_lock_ch]) gch = m_lock_ch;
    end else if (!mode) begin
      if (int'(sel) < C && in_valid[sel]) gch = int'(sel);
    end else begin
      for (int k = 1; k <= C; k++)
        if (gch < 0 && in_valid[(m_ptr + k) % C]) gch = (m_ptr + k) % C;
    end
    exp_rdy = '0;
    if (ld && gch >= 0) exp_rdy[gch] = 1'b1;
    #1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (ld && gch >= 0) begin
      sb.push_back('{gch, in_data[gch*W +: W]});
      m_ptr   = gch;
      m_valid = 1'b1;
`ifdef STREAM_MUX_LOCK_EN
      if (!m_locked && !in_last[gch]) begin
        m_locked  = 1'b1;
        m_lock_ch = gch;
      end else if (m_locked && in_last[gch]) begin
        m_locked = 1'b0;
      end
`endif
    end else if (ld) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
  endtask

  task automatic model_reset();
    sb.delete();
    m_ptr     = C - 1;
    m_valid   = 1'b0;
    m_locked  = 1'b0;
    m_lock_ch = 0;
  endtask

  initial begin
    logic [W-1:0] held;
    rst_n     = 1'b0;
    in_valid  = '1;
    in_data   = {$urandom, $urandom};
    mode      = 1'b0;
    sel       = '0;
    out_ready = 1'b1;
    in_data5  = '0;
    in_valid5 = '0;
    mode5     = 1'b0;
    sel5      = '0;
    out_ready5 = 1'b1;
`ifdef STREAM_MUX_LOCK_EN
    in_last   = '1;
    in_last5  = '1;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_chan", 32'(out_chan), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;

    // Fixed select on channel 5, then channel 5 goes idle.
    mode = 1'b0; sel = 3'd5; in_valid = 8'h20;
    in_data = '0; in_data[5*W +: W] = 8'hA5;
    step();
    chk("fixed_out_data", 32'(out_data), 32'hA5);
    chk("fixed_out_chan", 32'(out_chan), 32'd5);
    in_valid = '0;
    step();

    // Round-robin fairness, all valid then only channels 2 and 6.
    mode = 1'b1; in_valid = '1;
    for (int k = 0; k < C; k++) in_data[k*W +: W] = 8'(8'h10 + k);
    repeat (10) step();
    in_valid = 8'h44;
    repeat (3) step();

    // Backpressure: load one beat then stall three cycles.
    in_valid = '1;
    step();
    held = out_data;
    out_ready = 1'b0;
    repeat (3) begin
      step();
      chk("stall_data", 32'(out_data), 32'(held));
    end
    out_ready = 1'b1;
    step();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      in_valid  = C'($urandom);
      in_data   = {$urandom, $urandom};
      mode      = ($urandom_range(0, 3) != 0);
      sel       = SW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef STREAM_MUX_LOCK_EN
      in_last   = C'($urandom);
`endif
      step();
    end

`ifdef STREAM_MUX_LOCK_EN
    // Packet lock: channel 1 sends three beats, channel 3 waits until the last one.
    out_ready = 1'b1; in_valid = '0; in_last = '1;
    repeat (3) step();
    mode = 1'b1; in_valid = 8'h0A; in_last = 8'h00;
    repeat (2) step();
    in_last = 8'h02;
    repeat (3) step();
    in_last = '1;
`endif

    // Reset while a beat is held.
    mode = 1'b1; in_valid = '1; out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_rst_first_rr", 32'(out_chan), 32'd0);

    // Five-channel instance: out-of-range selects never grant.
    in_valid = '0;
    in_valid5 = '1; in_data5 = {$urandom, 8'(W)};
    for (int s = 5; s < 8; s++) begin
      sel5 = 3'(s);
      step();
      chk("sel_oor_in_ready", 32'(in_ready5), 32'd0);
      chk("sel_oor_out_valid", 32'(out_valid5), 32'd0);
    end
    sel5 = 3'd4;
    #1;
    chk("sel_edge_in_ready", 32'(in_ready5), 32'h10);
    in_valid5 = '0;

    // Drain and confirm every predicted beat appeared.
    in_valid = '0; out_ready = 1'b1;
    repeat (3) step();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
